// File: rtl/stepper_phase_seq_pkg.sv
// Shared types and the 4-phase coil table for stepper drive blocks.
// Provides phase index/position typedefs and the phase-advance rule.
package stepper_phase_seq_pkg;

   typedef logic [2:0]         phase_idx_t;
   typedef logic signed [15:0] pos_t;
   typedef logic [3:0]         coil_t;

   // Even entries are single-coil, odd entries are two-coil patterns.
   localparam coil_t PHASE_TABLE [8] = '{
      4'b0001, 4'b0011, 4'b0010, 4'b0110,
      4'b0100, 4'b1100, 4'b1000, 4'b1001
   };

   // Full-step moves from an even index by one to land on a two-coil entry.
   function automatic phase_idx_t next_index(phase_idx_t idx, logic fwd, logic half);
      phase_idx_t inc;
      inc = (half || !idx[0]) ? 3'd1 : 3'd2;
      return fwd ? phase_idx_t'(idx + inc) : phase_idx_t'(idx - inc);
   endfunction

endpackage

// File: rtl/stepper_phase_seq_if.sv
// Control and status bundle between a stepper phase sequencer and its controller.
interface stepper_phase_seq_if;
   import stepper_phase_seq_pkg::*;

   logic  enable;
   logic  step_in;
   logic  dir;
   logic  half_step;
   logic  clr_pos;
   coil_t coil;
   pos_t  position;
   logic  step_stb;
   logic  energized;
   logic  limit_hit;

   modport master (
      output enable, step_in, dir, half_step, clr_pos,
      input  coil, position, step_stb, energized, limit_hit
   );

   modport slave (
      input  enable, step_in, dir, half_step, clr_pos,
      output coil, position, step_stb, energized, limit_hit
   );
endinterface

// File: rtl/stepper_phase_seq_in_sync_edge.sv
// Two-flop synchronizer with a third flop for rising-edge detection.
module stepper_phase_seq_in_sync_edge (
   input  logic clk_in,
   input  logic rst_n,
   input  logic d,
   output logic sync,
   output logic rise
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q, dly_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/stepper_phase_seq.sv
// Stepper phase sequencer: step/dir pulses -> 4-phase coil drive, signed position, idle de-energize.
// Define STEP_LIMIT_EN to reject steps beyond POS_MIN/POS_MAX and raise a sticky limit_hit.
module stepper_phase_seq
   import stepper_phase_seq_pkg::*;
#(
   parameter int IDLE_CYCLES = 50000000,
   parameter int IDLE_W      = 26,
   parameter int POS_MIN     = -32768,
   parameter int POS_MAX     = 32767
) (
   input logic                clk_in,
   input logic                rst_n,
   stepper_phase_seq_if.slave bus
);

   localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(IDLE_CYCLES);
   localparam bit                IDLE_EN   = (IDLE_CYCLES != 0);
   localparam logic signed [16:0] POS_MIN_X = 17'(POS_MIN);
   localparam logic signed [16:0] POS_MAX_X = 17'(POS_MAX);
`ifdef STEP_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   logic step_rise;
   logic step_sync_unused;
   logic dir_sync;
   logic dir_rise_unused;

   stepper_phase_seq_in_sync_edge u_step_sync (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .d      (bus.step_in),
      .sync   (step_sync_unused),
      .rise   (step_rise)
   );

   stepper_phase_seq_in_sync_edge u_dir_sync (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .d      (bus.dir),
      .sync   (dir_sync),
      .rise   (dir_rise_unused)
   );

   phase_idx_t        idx_q, idx_d;
   pos_t              pos_q, pos_d;
   coil_t             coil_q, coil_d;
   logic              stb_q, stb_d;
   logic              energized_q, energized_d;
   logic              limit_q, limit_d;
   logic [IDLE_W-1:0] idle_q, idle_d;

   logic signed [16:0] pos_try;
   logic               in_range;
   logic               accept;
   logic               reject;
   logic               idle_hit;

   always_comb begin
      pos_try  = $signed({pos_q[15], pos_q}) + (dir_sync ? 17'sd1 : -17'sd1);
      in_range = (pos_try >= POS_MIN_X) && (pos_try <= POS_MAX_X);
      accept   = step_rise && bus.enable && (!LIMIT_EN || in_range);
      reject   = step_rise && bus.enable && LIMIT_EN && !in_range;

      idx_d = idx_q;
      if (accept) idx_d = next_index(idx_q, dir_sync, bus.half_step);

      // A clear in the same cycle as a step wins over the increment.
      pos_d = pos_q;
      if (bus.clr_pos)  pos_d = '0;
      else if (accept)  pos_d = pos_t'(pos_try[15:0]);

      limit_d = limit_q;
      if (reject)           limit_d = 1'b1;
      else if (bus.clr_pos) limit_d = 1'b0;

      idle_d = idle_q;
      if (!bus.enable || accept || !IDLE_EN) idle_d = '0;
      else if (idle_q != IDLE_LIM)           idle_d = idle_q + IDLE_W'(1);

      // The index is kept while de-energized so the next step resumes in sequence.
      idle_hit    = IDLE_EN && (idle_d == IDLE_LIM);
      coil_d      = (bus.enable && !idle_hit) ? PHASE_TABLE[idx_d] : '0;
      energized_d = (coil_d != '0);
      stb_d       = accept;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         pos_q       <= '0;
         coil_q      <= '0;
         stb_q       <= 1'b0;
         energized_q <= 1'b0;
         limit_q     <= 1'b0;
         idle_q      <= '0;
      end else begin
         idx_q       <= idx_d;
         pos_q       <= pos_d;
         coil_q      <= coil_d;
         stb_q       <= stb_d;
         energized_q <= energized_d;
         limit_q     <= limit_d;
         idle_q      <= idle_d;
      end
   end

   assign bus.coil      = coil_q;
   assign bus.position  = pos_q;
   assign bus.step_stb  = stb_q;
   assign bus.energized = energized_q;
   assign bus.limit_hit = LIMIT_EN ? limit_q : 1'b0;

endmodule
